alu_sequencer: RTL and testbench
================================

Name: alu_sequencer

Overview:
Program-sequencing control unit for the 8-bit ALU/accumulator/register-file datapath. It fetches 16-bit instructions from a synchronous program memory, decodes them, and drives every datapath control input for the required number of cycles. It also supports conditional and unconditional jumps, data-memory load/store and halt. It sits between the program memory, the data memory and the ALU block in the CPU top level.

Parameters:
PM_ADDR_W, 8, program-memory address width (PC width); PC wraps modulo 2^PM_ADDR_W
DM_ADDR_W, 8, data-memory address width; must be <= 8 (taken from instruction bits [7:0])

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  asynchronous active-low reset
i_start  in  1  start/restart pulse; ignored unless state is IDLE or HALT
i_pm_data  in  16  program-memory read data, valid 1 cycle after o_pm_addr
i_acumulator  in  8  accumulator value fed back from the ALU block (used by JZ and ST_DM)
o_pm_addr  out  PM_ADDR_W  program-memory address (= PC)
o_dm_addr  out  DM_ADDR_W  data-memory address
o_dm_we  out  1  data-memory write enable
o_dm_wdata  out  8  data-memory write data (= i_acumulator)
o_acumulator_ce  out  1  accumulator clock enable
o_operation_code  out  3  ALU operation code (pkg operation encoding)
o_register_file_ce  out  3  register-file write select: 0..3 writes, 3'b111 idle
o_register_file_mux_addr  out  2  register-file read select
o_data_memory_read_enable  out  1  selects DM data as the ALU argument
o_direct_data  out  8  immediate value
o_direct_load  out  1  accumulator loads o_direct_data
o_busy  out  1  high in FETCH/DECODE/MEM/EXEC
o_halted  out  1  high in HALT
o_illegal  out  1  one-cycle pulse in EXEC for an undefined class

Behaviour:
- Instruction fields: [15:12] class, [10:8] ALU op, [7:0] imm/address, [1:0] RF index.
- Class encoding: 0 NOP; 1 ALU_RF; 2 ALU_DM; 3 LDI; 4 ST_RF; 5 ST_DM; 6 JMP; 7 JZ; F HALT; other values are illegal and execute as NOP.
- FSM states: IDLE, FETCH, DECODE, MEM, EXEC, HALT.
  - IDLE or HALT with i_start -> FETCH, PC <= 0.
  - FETCH -> DECODE.
  - DECODE: IR <= i_pm_data; PC <= PC+1 (wraps). ALU_DM goes to MEM; all other classes go to EXEC.
  - MEM -> EXEC.
  - EXEC: HALT class goes to HALT; all other classes go to FETCH.
- Latency: 3 cycles per instruction; ALU_DM takes 4 cycles.
- Control outputs are a combinational decode of state and IR. Outside EXEC they hold idle values, except o_dm_addr in MEM.
- Idle values: acc_ce 0, op 3'b110 (LD), rf_ce 3'b111, mux 0, dm_re 0, direct_data 0, direct_load 0, dm_we 0, dm_addr 0. All outputs take these values at reset; state=IDLE, PC=0, IR=0.
- Per-class EXEC behaviour:
  - ALU_RF: acc_ce=1, op=IR[10:8], mux=IR[1:0].
  - ALU_DM: o_dm_addr=IR[7:0] in MEM and EXEC; in EXEC also dm_re=1, acc_ce=1, op=IR[10:8].
  - LDI: acc_ce=1, direct_load=1, direct_data=IR[7:0].
  - ST_RF: rf_ce={1'b0,IR[1:0]}.
  - ST_DM: dm_we=1, dm_addr=IR[7:0].
  - JMP: PC <= IR[PM_ADDR_W-1:0].
  - JZ: PC <= target only when i_acumulator==0; otherwise PC keeps PC+1.
  - NOP and HALT: no datapath action.
- A jump in EXEC overrides the DECODE increment. A jump to the current address is legal (infinite loop).
- i_start while busy: no effect.
- Reset asserted mid-instruction: immediate return to IDLE with idle outputs. No partial write may occur after reset asserts.
- PC at max value: the increment wraps to 0 with no flag.

Decomposition:
- Shared pkg gains:
  - instr_class_e enum (4-bit)
  - seq_state_e enum
  - RF_CE_IDLE = 3'b111
  - OP_LD = 3'b110
  - INSTR_W = 16
  - field position constants
- Existing operation enum is reused for o_operation_code.
- One combinational sub-module, alu_seq_decoder: takes state and IR, produces all control outputs and o_illegal. alu_sequencer keeps the FSM, PC and IR.

Test Plan:
- Reset low mid-EXEC of LDI -> outputs at idle values immediately; after release and i_start, o_pm_addr=0 in the first FETCH.
- Program LDI 0x05; ST_RF r2; LDI 0x03; ALU_RF ADD r2; HALT -> accumulator 0x08 at HALT; o_halted=1; 15 cycles from the first FETCH to HALT.
- ALU_DM SUB addr 0x10 with DM[0x10]=0x02, acc=0x07 -> dm_addr=0x10 in MEM and EXEC, dm_re=1 only in EXEC; accumulator 0x05.
- JZ 0x20 with acc=0 -> next o_pm_addr=0x20; with acc=0x01 -> next o_pm_addr=PC+1.
- Class 0xA at PC=0xFF -> o_illegal pulses 1 cycle, no datapath enable; next fetch address 0x00 (wrap).
- ST_DM addr 0x33 with acc=0x5A -> dm_we=1 for exactly 1 cycle with wdata=0x5A; i_start pulsed while busy changes nothing.

Source files
------------

// File: rtl/alu_sequencer_pkg.sv
// Shared types and constants for the ALU program sequencer: instruction fields,
// instruction classes, sequencer states and the ALU operation encoding.
package alu_sequencer_pkg;

  localparam int unsigned INSTR_W   = 16;
  localparam int unsigned CLASS_MSB = 15;
  localparam int unsigned CLASS_LSB = 12;
  localparam int unsigned OP_MSB    = 10;
  localparam int unsigned OP_LSB    = 8;
  localparam int unsigned IMM_MSB   = 7;
  localparam int unsigned IMM_LSB   = 0;
  localparam int unsigned RF_MSB    = 1;
  localparam int unsigned RF_LSB    = 0;

  typedef enum logic [2:0] {
    OpAdd  = 3'd0,
    OpSub  = 3'd1,
    OpAnd  = 3'd2,
    OpOr   = 3'd3,
    OpXor  = 3'd4,
    OpNot  = 3'd5,
    OpLd   = 3'd6,
    OpPass = 3'd7
  } operation_e;

  localparam logic [2:0] OP_LD      = 3'b110;
  localparam logic [2:0] RF_CE_IDLE = 3'b111;

  typedef enum logic [3:0] {
    ClsNop   = 4'h0,
    ClsAluRf = 4'h1,
    ClsAluDm = 4'h2,
    ClsLdi   = 4'h3,
    ClsStRf  = 4'h4,
    ClsStDm  = 4'h5,
    ClsJmp   = 4'h6,
    ClsJz    = 4'h7,
    ClsHalt  = 4'hF
  } instr_class_e;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StMem,
    StExec,
    StHalt
  } seq_state_e;

endpackage

// File: rtl/alu_seq_decoder.sv
// Combinational control decode: maps sequencer state and IR onto the datapath
// control inputs, holding idle values outside EXEC (dm address also in MEM).
module alu_seq_decoder
  import alu_sequencer_pkg::*;
#(
  parameter int unsigned DM_ADDR_W = 8
) (
  input  seq_state_e           state_i,
  input  logic [INSTR_W-1:0]   ir_i,
  output logic [DM_ADDR_W-1:0] dm_addr_o,
  output logic                 dm_we_o,
  output logic                 acc_ce_o,
  output logic [2:0]           op_o,
  output logic [2:0]           rf_ce_o,
  output logic [1:0]           mux_o,
  output logic                 dm_re_o,
  output logic [7:0]           direct_data_o,
  output logic                 direct_load_o,
  output logic                 illegal_o
);

  logic [3:0] cls;
  logic       unused_ir;

  assign cls       = ir_i[CLASS_MSB:CLASS_LSB];
  assign unused_ir = ir_i[11];

  always_comb begin
    dm_addr_o     = '0;
    dm_we_o       = 1'b0;
    acc_ce_o      = 1'b0;
    op_o          = OP_LD;
    rf_ce_o       = RF_CE_IDLE;
    mux_o         = 2'd0;
    dm_re_o       = 1'b0;
    direct_data_o = 8'd0;
    direct_load_o = 1'b0;
    illegal_o     = 1'b0;

    // Data-memory address is presented one cycle early so the read is ready in EXEC.
    if (state_i == StMem && cls == ClsAluDm) begin
      dm_addr_o = ir_i[DM_ADDR_W-1:0];
    end

    if (state_i == StExec) begin
      case (cls)
        ClsNop, ClsJmp, ClsJz, ClsHalt: ;
        ClsAluRf: begin
          acc_ce_o = 1'b1;
          op_o     = ir_i[OP_MSB:OP_LSB];
          mux_o    = ir_i[RF_MSB:RF_LSB];
        end
        ClsAluDm: begin
          dm_addr_o = ir_i[DM_ADDR_W-1:0];
          dm_re_o   = 1'b1;
          acc_ce_o  = 1'b1;
          op_o      = ir_i[OP_MSB:OP_LSB];
        end
        ClsLdi: begin
          acc_ce_o      = 1'b1;
          direct_load_o = 1'b1;
          direct_data_o = ir_i[IMM_MSB:IMM_LSB];
        end
        ClsStRf: rf_ce_o = {1'b0, ir_i[RF_MSB:RF_LSB]};
        ClsStDm: begin
          dm_we_o   = 1'b1;
          dm_addr_o = ir_i[DM_ADDR_W-1:0];
        end
        default: illegal_o = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/alu_sequencer.sv
// Program sequencer for the 8-bit ALU datapath: fetch/decode/execute FSM with
// PC and IR; datapath control decode lives in alu_seq_decoder.
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int unsigned PM_ADDR_W = 8,
  parameter int unsigned DM_ADDR_W = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic [INSTR_W-1:0]   i_pm_data,
  input  logic [7:0]           i_acumulator,
  output logic [PM_ADDR_W-1:0] o_pm_addr,
  output logic [DM_ADDR_W-1:0] o_dm_addr,
  output logic                 o_dm_we,
  output logic [7:0]           o_dm_wdata,
  output logic                 o_acumulator_ce,
  output logic [2:0]           o_operation_code,
  output logic [2:0]           o_register_file_ce,
  output logic [1:0]           o_register_file_mux_addr,
  output logic                 o_data_memory_read_enable,
  output logic [7:0]           o_direct_data,
  output logic                 o_direct_load,
  output logic                 o_busy,
  output logic                 o_halted,
  output logic                 o_illegal
);

  seq_state_e           state_q, state_d;
  logic [PM_ADDR_W-1:0] pc_q, pc_d;
  logic [INSTR_W-1:0]   ir_q, ir_d;
  logic [3:0]           ir_cls;
  logic                 jump_taken;

  assign ir_cls     = ir_q[CLASS_MSB:CLASS_LSB];
  assign jump_taken = (ir_cls == ClsJmp) || (ir_cls == ClsJz && i_acumulator == 8'd0);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    unique case (state_q)
      StIdle, StHalt: begin
        if (i_start) begin
          state_d = StFetch;
          pc_d    = '0;
        end
      end
      StFetch: state_d = StDecode;
      StDecode: begin
        ir_d    = i_pm_data;
        pc_d    = pc_q + 1'b1;
        state_d = (i_pm_data[CLASS_MSB:CLASS_LSB] == ClsAluDm) ? StMem : StExec;
      end
      StMem: state_d = StExec;
      StExec: begin
        // Jump target overrides the increment already applied in DECODE.
        if (jump_taken) begin
          pc_d = ir_q[PM_ADDR_W-1:0];
        end
        state_d = (ir_cls == ClsHalt) ? StHalt : StFetch;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
      pc_q    <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  assign o_pm_addr  = pc_q;
  assign o_dm_wdata = i_acumulator;
  assign o_busy     = (state_q == StFetch) || (state_q == StDecode) ||
                      (state_q == StMem) || (state_q == StExec);
  assign o_halted   = (state_q == StHalt);

  alu_seq_decoder #(
    .DM_ADDR_W (DM_ADDR_W)
  ) u_decoder (
    .state_i       (state_q),
    .ir_i          (ir_q),
    .dm_addr_o     (o_dm_addr),
    .dm_we_o       (o_dm_we),
    .acc_ce_o      (o_acumulator_ce),
    .op_o          (o_operation_code),
    .rf_ce_o       (o_register_file_ce),
    .mux_o         (o_register_file_mux_addr),
    .dm_re_o       (o_data_memory_read_enable),
    .direct_data_o (o_direct_data),
    .direct_load_o (o_direct_load),
    .illegal_o     (o_illegal)
  );

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a small behavioural program memory,
// accumulator, register file and data memory around it.
module tb_alu_sequencer;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_start = 1'b0;
  logic [15:0] i_pm_data;
  logic [7:0]  o_pm_addr;
  logic [7:0]  o_dm_addr;
  logic        o_dm_we;
  logic [7:0]  o_dm_wdata;
  logic        o_acumulator_ce;
  logic [2:0]  o_operation_code;
  logic [2:0]  o_register_file_ce;
  logic [1:0]  o_register_file_mux_addr;
  logic        o_data_memory_read_enable;
  logic [7:0]  o_direct_data;
  logic        o_direct_load;
  logic        o_busy;
  logic        o_halted;
  logic        o_illegal;

  logic [15:0] pm [256];
  logic [7:0]  dm [256];
  logic [7:0]  rf [4];
  logic [7:0]  acc = 8'hEE;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 i_clk = ~i_clk;

  alu_sequencer dut (
    .i_clk                     (i_clk),
    .i_rst_n                   (i_rst_n),
    .i_start                   (i_start),
    .i_pm_data                 (i_pm_data),
    .i_acumulator              (acc),
    .o_pm_addr                 (o_pm_addr),
    .o_dm_addr                 (o_dm_addr),
    .o_dm_we                   (o_dm_we),
    .o_dm_wdata                (o_dm_wdata),
    .o_acumulator_ce           (o_acumulator_ce),
    .o_operation_code          (o_operation_code),
    .o_register_file_ce        (o_register_file_ce),
    .o_register_file_mux_addr  (o_register_file_mux_addr),
    .o_data_memory_read_enable (o_data_memory_read_enable),
    .o_direct_data             (o_direct_data),
    .o_direct_load             (o_direct_load),
    .o_busy                    (o_busy),
    .o_halted                  (o_halted),
    .o_illegal                 (o_illegal)
  );

  function automatic logic [7:0] alu(input logic [2:0] op, input logic [7:0] a,
                                     input logic [7:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return ~b;
      3'd6:    return b;
      default: return a;
    endcase
  endfunction

  // Environment datapath driven by the sequencer's control outputs.
  always @(posedge i_clk) begin
    i_pm_data <= pm[o_pm_addr];
    if (o_acumulator_ce) begin
      if (o_direct_load) acc <= o_direct_data;
      else acc <= alu(o_operation_code, acc,
                      o_data_memory_read_enable ? dm[o_dm_addr] : rf[o_register_file_mux_addr]);
    end
    if (o_register_file_ce != 3'b111) rf[o_register_file_ce[1:0]] <= acc;
    if (o_dm_we) dm[o_dm_addr] <= o_dm_wdata;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_acc_ce"}, o_acumulator_ce, 0);
    check_eq({tag, "_op"}, o_operation_code, 3'b110);
    check_eq({tag, "_rf_ce"}, o_register_file_ce, 3'b111);
    check_eq({tag, "_mux"}, o_register_file_mux_addr, 0);
    check_eq({tag, "_dm_re"}, o_data_memory_read_enable, 0);
    check_eq({tag, "_ddata"}, o_direct_data, 0);
    check_eq({tag, "_dload"}, o_direct_load, 0);
    check_eq({tag, "_dm_we"}, o_dm_we, 0);
    check_eq({tag, "_dm_addr"}, o_dm_addr, 0);
    check_eq({tag, "_illegal"}, o_illegal, 0);
  endtask

  task automatic do_reset();
    i_start = 1'b0;
    i_rst_n = 1'b0;
    #4;
    i_rst_n = 1'b1;
    step();
  endtask

  task automatic clear_pm();
    for (int a = 0; a < 256; a++) pm[a] = 16'hF000;
  endtask

  // Leaves the bench at cycle 0 (first FETCH) of the program.
  task automatic start_prog();
    i_start = 1'b1;
    step();
    i_start = 1'b0;
  endtask

  task automatic wait_halt(input int max, output int n);
    n = 0;
    while (!o_halted && n < max) begin
      step();
      n++;
    end
    check_eq("halt_timeout", o_halted, 1);
  endtask

  int cyc;
  int we_cnt;

  initial begin
    clear_pm();
    #2;
    check_idle("rst");
    check_eq("rst_pm_addr", o_pm_addr, 0);
    check_eq("rst_busy", o_busy, 0);
    check_eq("rst_halted", o_halted, 0);
    i_rst_n = 1'b1;
    step();

    // Reset asserted during LDI EXEC: idle at once, no accumulator write.
    pm[0] = 16'h3005;
    start_prog();
    step(2);
    check_eq("ldi_exec_dload", o_direct_load, 1);
    #2;
    i_rst_n = 1'b0;
    #1;
    check_idle("midrst");
    check_eq("midrst_busy", o_busy, 0);
    @(posedge i_clk);
    #1;
    check_eq("midrst_no_write", acc, 8'hEE);
    do_reset();
    start_prog();
    check_eq("restart_pm_addr", o_pm_addr, 0);
    check_eq("restart_busy", o_busy, 1);
    do_reset();

    // LDI 5; ST_RF r2; LDI 3; ADD r2; HALT
    pm[0] = 16'h3005; pm[1] = 16'h4002; pm[2] = 16'h3003; pm[3] = 16'h1002;
    pm[4] = 16'hF000;
    start_prog();
    wait_halt(60, cyc);
    check_eq("prog_cycles", cyc, 15);
    check_eq("prog_acc", acc, 8'h08);
    check_eq("prog_rf2", rf[2], 8'h05);
    check_eq("prog_halted", o_halted, 1);
    check_eq("prog_busy", o_busy, 0);

    // Restart from HALT: LDI 2; ST_DM 0x10; LDI 7; ALU_DM SUB 0x10; HALT
    clear_pm();
    pm[0] = 16'h3002; pm[1] = 16'h5010; pm[2] = 16'h3007; pm[3] = 16'h2110;
    start_prog();
    check_eq("halt_restart_pc", o_pm_addr, 0);
    step(10);
    check_eq("aludm_dec_addr", o_dm_addr, 0);
    step();
    check_eq("aludm_mem_addr", o_dm_addr, 8'h10);
    check_eq("aludm_mem_re", o_data_memory_read_enable, 0);
    check_eq("aludm_mem_ce", o_acumulator_ce, 0);
    check_eq("aludm_mem_busy", o_busy, 1);
    step();
    check_eq("aludm_exec_addr", o_dm_addr, 8'h10);
    check_eq("aludm_exec_re", o_data_memory_read_enable, 1);
    check_eq("aludm_exec_ce", o_acumulator_ce, 1);
    check_eq("aludm_exec_op", o_operation_code, 3'd1);
    step();
    check_eq("aludm_next_re", o_data_memory_read_enable, 0);
    check_eq("aludm_next_pc", o_pm_addr, 8'h04);
    wait_halt(20, cyc);
    check_eq("aludm_acc", acc, 8'h05);

    // JZ taken with acc == 0
    do_reset();
    clear_pm();
    pm[0] = 16'h3000; pm[1] = 16'h7020;
    start_prog();
    step(6);
    check_eq("jz_taken_pc", o_pm_addr, 8'h20);
    wait_halt(20, cyc);

    // JZ not taken with acc == 1
    do_reset();
    pm[0] = 16'h3001;
    start_prog();
    step(6);
    check_eq("jz_fall_pc", o_pm_addr, 8'h02);
    wait_halt(20, cyc);

    // Illegal class at PC 0xFF, then wrap to 0
    do_reset();
    clear_pm();
    pm[0] = 16'h60FF; pm[255] = 16'hA000;
    start_prog();
    step(3);
    check_eq("jmp_pc", o_pm_addr, 8'hFF);
    step(2);
    check_eq("ill_pulse", o_illegal, 1);
    check_eq("ill_acc_ce", o_acumulator_ce, 0);
    check_eq("ill_rf_ce", o_register_file_ce, 3'b111);
    check_eq("ill_dm_we", o_dm_we, 0);
    check_eq("ill_dload", o_direct_load, 0);
    step();
    check_eq("ill_clear", o_illegal, 0);
    check_eq("wrap_pc", o_pm_addr, 8'h00);

    // LDI 0x5A; ST_DM 0x33; HALT with a start pulse while busy
    do_reset();
    clear_pm();
    pm[0] = 16'h305A; pm[1] = 16'h5033;
    start_prog();
    cyc = 0;
    we_cnt = 0;
    while (!o_halted && cyc < 40) begin
      i_start = (cyc == 4);
      step();
      cyc++;
      if (o_dm_we) begin
        we_cnt++;
        check_eq("stdm_wdata", o_dm_wdata, 8'h5A);
        check_eq("stdm_addr", o_dm_addr, 8'h33);
      end
    end
    i_start = 1'b0;
    check_eq("stdm_halted", o_halted, 1);
    check_eq("stdm_cycles", cyc, 9);
    check_eq("stdm_we_cnt", we_cnt, 1);
    check_eq("stdm_mem", dm[8'h33], 8'h5A);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
